tea_arb_ctrl: RTL and testbench

Iterative TEA encryption engine shared between two requesters. It runs one TEA cycle (both 32-bit halves) per clock through a single combinational round, so a block takes 32 clocks. It sits beside the fully pipelined TEA datapath as the low-area option for designs where throughput is not critical. A round-robin arbiter picks between two valid/ready request ports, and each result is returned on one response port tagged with the requester id.

---
 rtl/tea_pkg.sv | 34 +++
 rtl/tea_round.sv | 23 ++
 rtl/tea_arb_ctrl.sv | 133 +++++++++++++
 tb/tb_tea_arb_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tea_pkg.sv
// tea_pkg: shared TEA definitions.
//   TEA_ROUNDS / TEA_DELTA : cycles per block and key-schedule constant.
//   tea_state_e            : control FSM states for the iterative engine.
//   tea_key_t + key_k0..k3 : 128-bit key {k3,k2,k1,k0} and its word slices.
package tea_pkg;

    localparam int          TEA_ROUNDS = 32;
    localparam logic [31:0] TEA_DELTA  = 32'h9E3779B9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tea_state_e;

    typedef logic [127:0] tea_key_t;

    function automatic logic [31:0] key_k0(input tea_key_t k);
        return k[31:0];
    endfunction

    function automatic logic [31:0] key_k1(input tea_key_t k);
        return k[63:32];
    endfunction

    function automatic logic [31:0] key_k2(input tea_key_t k);
        return k[95:64];
    endfunction

    function automatic logic [31:0] key_k3(input tea_key_t k);
        return k[127:96];
    endfunction

endpackage

// File: rtl/tea_round.sv
// tea_round: one combinational TEA cycle (both halves).
//   v0_i, v1_i : current halves      sum_i : running key-schedule sum
//   k0_i..k3_i : key words           v0_o, v1_o : halves after this cycle
// All arithmetic is modulo 2^32 with logical shifts.
module tea_round (
    input  logic [31:0] v0_i,
    input  logic [31:0] v1_i,
    input  logic [31:0] sum_i,
    input  logic [31:0] k0_i,
    input  logic [31:0] k1_i,
    input  logic [31:0] k2_i,
    input  logic [31:0] k3_i,
    output logic [31:0] v0_o,
    output logic [31:0] v1_o
);

    // The second half uses the already-updated first half.
    always_comb begin
        v0_o = v0_i + (((v1_i << 4) + k0_i) ^ (v1_i + sum_i) ^ ((v1_i >> 5) + k1_i));
        v1_o = v1_i + (((v0_o << 4) + k2_i) ^ (v0_o + sum_i) ^ ((v0_o >> 5) + k3_i));
    end

endmodule

// File: rtl/tea_arb_ctrl.sv
// tea_arb_ctrl: iterative TEA encryptor shared by two requesters.
//   clk, nrst                 : clock, async active-low reset
//   reqN_valid/ready          : request handshake for requester N (0/1)
//   reqN_v0, reqN_v1, reqN_key: plaintext halves and key {k3,k2,k1,k0}
//   rsp_valid/ready           : response handshake
//   rsp_id                    : requester owning the result
//   rsp_v0, rsp_v1            : ciphertext halves
//   busy                      : block in flight or waiting to be taken
// A round-robin arbiter picks a requester in IDLE; the block then runs one
// TEA cycle per clock for ROUNDS clocks and is held in DONE until taken.
module tea_arb_ctrl
    import tea_pkg::*;
#(
    parameter int          ROUNDS = TEA_ROUNDS,
    parameter logic [31:0] DELTA  = TEA_DELTA
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [31:0]   req0_v0,
    input  logic [31:0]   req0_v1,
    input  logic [127:0]  req0_key,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [31:0]   req1_v0,
    input  logic [31:0]   req1_v1,
    input  logic [127:0]  req1_key,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [31:0]   rsp_v0,
    output logic [31:0]   rsp_v1,
    output logic          busy
);

    localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    tea_state_e    state_q, state_d;
    logic [31:0]   v0_q, v0_d, v1_q, v1_d, sum_q, sum_d;
    tea_key_t      key_q, key_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          id_q, id_d;
    logic          last_q, last_d;
    logic          sel0, sel1, accept;
    logic [31:0]   rnd_v0, rnd_v1;

    // Round-robin: on a tie the port that did not win last time goes next.
    assign sel0 = req0_valid & (~req1_valid | last_q);
    assign sel1 = req1_valid & (~req0_valid | ~last_q);

    assign req0_ready = (state_q == IDLE) & sel0;
    assign req1_ready = (state_q == IDLE) & sel1;
    assign accept     = req0_ready | req1_ready;

    tea_round u_round (
        .v0_i  (v0_q),
        .v1_i  (v1_q),
        .sum_i (sum_q),
        .k0_i  (key_k0(key_q)),
        .k1_i  (key_k1(key_q)),
        .k2_i  (key_k2(key_q)),
        .k3_i  (key_k3(key_q)),
        .v0_o  (rnd_v0),
        .v1_o  (rnd_v1)
    );

    always_comb begin
        state_d = state_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        sum_d   = sum_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    v0_d    = req1_ready ? req1_v0  : req0_v0;
                    v1_d    = req1_ready ? req1_v1  : req0_v1;
                    key_d   = req1_ready ? req1_key : req0_key;
                    sum_d   = DELTA;
                    cnt_d   = '0;
                    id_d    = req1_ready;
                    last_d  = req1_ready;
                    state_d = RUN;
                end
            end
            RUN: begin
                v0_d  = rnd_v0;
                v1_d  = rnd_v1;
                sum_d = sum_q + DELTA;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ROUNDS - 1)) state_d = DONE;
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            v0_q    <= '0;
            v1_q    <= '0;
            sum_q   <= '0;
            key_q   <= '0;
            cnt_q   <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;   // port 0 wins the first tie
        end else begin
            state_q <= state_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            sum_q   <= sum_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    // Response comes straight from the working registers, which are frozen in DONE.
    assign rsp_valid = (state_q == DONE);
    assign rsp_id    = id_q;
    assign rsp_v0    = v0_q;
    assign rsp_v1    = v1_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_tea_arb_ctrl.sv
module tb_tea_arb_ctrl;

    logic          clk = 1'b0;
    logic          nrst;
    logic          r0v, r1v, rsp_ready;
    logic [31:0]   r0a, r0b, r1a, r1b;
    logic [127:0]  r0k, r1k;
    logic          req0_ready, req1_ready, rsp_valid, rsp_id, busy;
    logic [31:0]   rsp_v0, rsp_v1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tea_arb_ctrl dut (
        .clk(clk), .nrst(nrst),
        .req0_valid(r0v), .req0_ready(req0_ready), .req0_v0(r0a), .req0_v1(r0b), .req0_key(r0k),
        .req1_valid(r1v), .req1_ready(req1_ready), .req1_v0(r1a), .req1_v1(r1b), .req1_key(r1k),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_v0(rsp_v0), .rsp_v1(rsp_v1), .busy(busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference TEA encryption, straight from the algorithm definition.
    function automatic logic [63:0] tea_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [127:0] k, input int n);
        logic [31:0] s;
        s = 0;
        for (int i = 0; i < n; i++) begin
            s = s + 32'h9E3779B9;
            a = a + (((b << 4) + k[31:0]) ^ (b + s) ^ ((b >> 5) + k[63:32]));
            b = b + (((a << 4) + k[95:64]) ^ (a + s) ^ ((a >> 5) + k[127:96]));
        end
        return {a, b};
    endfunction

    // ---------------- transaction-level model ----------------
    int          cyc = 0;
    bit          m_busy, m_done, m_last, m_id;
    int          m_run;
    logic [63:0] m_res;
    int          acc_t[$];
    bit          acc_id[$];
    bit          hs_id[$];

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_busy = 0; m_done = 0; m_last = 1; m_id = 0; m_run = 0;
        end else begin
            cyc++;
            if (!m_busy) begin
                if (r0v || r1v) begin
                    bit p;
                    p = (r0v && r1v) ? !m_last : r1v;
                    m_busy = 1; m_done = 0; m_run = 0; m_id = p; m_last = p;
                    m_res = p ? tea_ref(r1a, r1b, r1k, 32) : tea_ref(r0a, r0b, r0k, 32);
                    acc_t.push_back(cyc);
                    acc_id.push_back(p);
                end
            end else if (!m_done) begin
                m_run++;
                if (m_run == 32) m_done = 1;
            end else if (rsp_ready) begin
                hs_id.push_back(m_id);
                m_busy = 0; m_done = 0;
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (nrst === 1'b1) begin
            bit e0, e1;
            e0 = !m_busy && r0v && (!r1v || m_last);
            e1 = !m_busy && r1v && (!r0v || !m_last);
            chk("busy", 64'(busy), 64'(m_busy));
            chk("rsp_valid", 64'(rsp_valid), 64'(m_done));
            chk("req0_ready", 64'(req0_ready), 64'(e0));
            chk("req1_ready", 64'(req1_ready), 64'(e1));
            if (m_done) begin
                chk("rsp_data", {rsp_v0, rsp_v1}, m_res);
                chk("rsp_id", 64'(rsp_id), 64'(m_id));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int n, input string nm);
        int b;
        b = 0;
        while (acc_t.size() < n && b < 200) begin tick(); b++; end
        if (acc_t.size() < n) chk({nm, "_accept_timeout"}, 64'(acc_t.size()), 64'(n));
    endtask

    task automatic drain(input string nm);
        int b;
        b = 0;
        while (busy && b < 300) begin tick(); b++; end
        chk({nm, "_drain"}, 64'(busy), 64'(0));
    endtask

    task automatic do_reset();
        nrst = 0;
        tick(); tick();
        nrst = 1;
        tick();
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_rst_vld"}, 64'(rsp_valid), 0);
        chk({nm, "_rst_id"}, 64'(rsp_id), 0);
        chk({nm, "_rst_data"}, {rsp_v0, rsp_v1}, 0);
        chk({nm, "_rst_busy"}, 64'(busy), 0);
        chk({nm, "_rst_rdy"}, {62'd0, req1_ready, req0_ready}, 0);
    endtask

    initial begin
        int n, e, b;
        logic [63:0] snap;
        logic        snap_id;
        r0v = 0; r1v = 0; rsp_ready = 1;
        r0a = 0; r0b = 0; r1a = 0; r1b = 0; r0k = 0; r1k = 0;
        nrst = 0;
        tick(); tick();
        chk_reset_outputs("init");
        nrst = 1;
        tick();

        // Pin the reference model with hand-computed values.
        chk("model_1round", tea_ref(0, 0, 0, 1), 64'h9E3779B9_DBE8D32F);
        chk("model_kat", tea_ref(0, 0, 0, 32), 64'h41EA3A0A_94BAA940);

        // Known answer, fixed latency.
        r0v = 1;
        wait_acc(1, "kat");
        r0v = 0;
        e = acc_t[0];
        while (cyc < e + 31) tick();
        chk("kat_not_yet", 64'(rsp_valid), 0);
        tick();
        chk("kat_valid", 64'(rsp_valid), 1);
        chk("kat_data", {rsp_v0, rsp_v1}, 64'h41EA3A0A_94BAA940);
        chk("kat_id", 64'(rsp_id), 0);
        drain("kat");

        // Tie arbitration from reset: alternate 0,1,0,1 at 34-clock spacing.
        do_reset();
        n = acc_t.size();
        r0a = 32'h01234567; r0b = 32'h89ABCDEF; r0k = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        r1a = 32'hDEADBEEF; r1b = 32'hCAFEF00D; r1k = 128'hFFFFFFFF_00000000_12345678_9ABCDEF0;
        r0v = 1; r1v = 1;
        b = 0;
        while (acc_t.size() < n + 4 && b < 400) begin tick(); b++; end
        r0v = 0; r1v = 0;
        if (acc_t.size() < n + 4) chk("tie_timeout", 64'(acc_t.size()), 64'(n + 4));
        else begin
            for (int i = 0; i < 4; i++) chk("tie_order", 64'(acc_id[n + i]), 64'(i % 2));
            for (int i = 1; i < 4; i++) chk("tie_spacing", 64'(acc_t[n + i] - acc_t[n + i - 1]), 34);
        end
        drain("tie");
        if (hs_id.size() >= 4)
            for (int i = 0; i < 4; i++)
                chk("tie_rsp_order", 64'(hs_id[hs_id.size() - 4 + i]), 64'(i % 2));

        // Backpressure: stall 100 cycles with both requesters pending.
        rsp_ready = 0;
        r1a = 32'h0F1E2D3C; r1b = 32'h4B5A6978; r1k = 128'h0BADF00D_13579BDF_2468ACE0_FEEDFACE;
        n = acc_t.size();
        r1v = 1;
        wait_acc(n + 1, "bp");
        r0v = 1;
        b = 0;
        while (!rsp_valid && b < 40) begin tick(); b++; end
        chk("bp_valid_rise", 64'(rsp_valid), 1);
        chk("bp_data", {rsp_v0, rsp_v1}, tea_ref(32'h0F1E2D3C, 32'h4B5A6978, r1k, 32));
        snap = {rsp_v0, rsp_v1}; snap_id = rsp_id;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i % 25 == 0) begin
                chk("bp_hold_data", {rsp_v0, rsp_v1}, snap);
                chk("bp_hold_id", 64'(rsp_id), 64'(snap_id));
                chk("bp_hold_rdy", {62'd0, req1_ready, req0_ready}, 0);
            end
        end
        rsp_ready = 1;
        tick();
        r0v = 0; r1v = 0;
        chk("bp_handshake", 64'(rsp_valid), 0);
        drain("bp");

        // Single requester, random blocks.
        n = acc_t.size();
        e = hs_id.size();
        r1k = {$urandom, $urandom, $urandom, $urandom}; r1a = $urandom; r1b = $urandom;
        r1v = 1;
        b = 0;
        while (hs_id.size() < e + 200 && b < 7200) begin
            int s;
            s = acc_t.size();
            tick(); b++;
            if (acc_t.size() != s) begin
                r1k = {$urandom, $urandom, $urandom, $urandom}; r1a = $urandom; r1b = $urandom;
                if (acc_t.size() - n >= 200) r1v = 0;
            end
        end
        r1v = 0;
        chk("single_count", 64'(hs_id.size() - e), 200);
        begin
            int ones;
            ones = 0;
            for (int i = e; i < hs_id.size(); i++) ones += hs_id[i];
            chk("single_ids", 64'(ones), 64'(hs_id.size() - e));
        end
        drain("single");

        // Mid-run reset.
        n = acc_t.size();
        r0a = 32'h11111111; r0b = 32'h22222222; r0k = 128'h3;
        r0v = 1;
        wait_acc(n + 1, "mrst");
        r0v = 0;
        e = acc_t[n];
        while (cyc < e + 10) tick();
        nrst = 0;
        #1;
        chk_reset_outputs("mrst");
        tick(); tick();
        nrst = 1;
        for (int i = 0; i < 50; i++) tick();
        chk("mrst_no_rsp", 64'(rsp_valid), 0);
        chk("mrst_idle", 64'(busy), 0);

        // Busy/ready exclusion while running.
        n = acc_t.size();
        r0v = 1;
        wait_acc(n + 1, "excl");
        for (int i = 0; i < 20; i++) begin
            r0v = i[0]; r1v = i[1];
            #1;
            chk("excl_busy", 64'(busy), 1);
            chk("excl_rdy", {62'd0, req1_ready, req0_ready}, 0);
            tick();
        end
        r0v = 0; r1v = 0;
        drain("excl");
        chk("excl_one_accept", 64'(acc_t.size()), 64'(n + 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
